instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 22 ++
 rtl/instr_fetch.sv | 109 ++++++++++
 tb/tb_instr_fetch.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Instruction bus between the fetch unit (master) and instruction memory (slave).
// A read completes on a rising edge with instr_read=1 and instr_waitrequest=0.
interface instr_fetch_if;
  logic [31:0] instr_address;
  logic        instr_read;
  logic        instr_waitrequest;
  logic [31:0] instr_rdata;

  modport master (
    output instr_address,
    output instr_read,
    input  instr_waitrequest,
    input  instr_rdata
  );

  modport slave (
    input  instr_address,
    input  instr_read,
    output instr_waitrequest,
    output instr_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// MIPS-style fetch unit with one branch delay slot: FETCH -> EXEC -> FETCH, HALTED on redirect to HALT_ADDR.
// Latency: one FETCH cycle plus one per waitrequest stall; exec_stall and clk_enable=0 freeze all state.
module instr_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_enable,
  instr_fetch_if.master bus,
  output logic [31:0]   instr_readdata,
  output logic          instr_valid,
  output logic [31:0]   pc,
  output logic [31:0]   link_addr,
  input  logic [1:0]    pc_sel,
  input  logic          branch_cond,
  input  logic [31:0]   rs_data,
  input  logic          exec_stall,
  output logic          active
);

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    EXEC   = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt, ir_nxt;
  logic        redirect_pending, redirect_pending_nxt;
  logic [31:0] redirect_target, redirect_target_nxt;

  logic [31:0] pc_inc, branch_tgt, jump_tgt, jr_tgt, taken_tgt;
  logic        taken;

  assign pc_inc     = pc + 32'd4;
  assign branch_tgt = pc_inc + {{14{instr_readdata[15]}}, instr_readdata[15:0], 2'b00};
  assign jump_tgt   = {pc_inc[31:28], instr_readdata[25:0], 2'b00};
  assign jr_tgt     = rs_data & ~32'd3;

  assign taken = (pc_sel == 2'b10) || (pc_sel == 2'b11) || ((pc_sel == 2'b01) && branch_cond);

  always_comb begin
    taken_tgt = jr_tgt;
    case (pc_sel)
      2'b01:   taken_tgt = branch_tgt;
      2'b10:   taken_tgt = jump_tgt;
      default: taken_tgt = jr_tgt;
    endcase
  end

  always_comb begin
    state_nxt            = state;
    pc_nxt               = pc;
    ir_nxt               = instr_readdata;
    redirect_pending_nxt = redirect_pending;
    redirect_target_nxt  = redirect_target;
    case (state)
      FETCH: begin
        if (!bus.instr_waitrequest) begin
          ir_nxt    = bus.instr_rdata;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (!exec_stall) begin
          // A transfer seen while executing a delay slot is dropped.
          if (redirect_pending) begin
            pc_nxt               = redirect_target;
            redirect_pending_nxt = 1'b0;
            state_nxt            = (redirect_target == HALT_ADDR) ? HALTED : FETCH;
          end else begin
            pc_nxt    = pc_inc;
            state_nxt = FETCH;
            if (taken) begin
              redirect_pending_nxt = 1'b1;
              redirect_target_nxt  = taken_tgt;
            end
          end
        end
      end
      HALTED:  state_nxt = HALTED;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= FETCH;
      pc               <= RESET_VECTOR;
      instr_readdata   <= 32'd0;
      redirect_pending <= 1'b0;
      redirect_target  <= 32'd0;
    end else if (clk_enable) begin
      state            <= state_nxt;
      pc               <= pc_nxt;
      instr_readdata   <= ir_nxt;
      redirect_pending <= redirect_pending_nxt;
      redirect_target  <= redirect_target_nxt;
    end
  end

  assign bus.instr_read    = (state == FETCH) && !reset;
  assign bus.instr_address = {pc[31:2], 2'b00};
  assign instr_valid       = (state == EXEC) && !reset;
  assign active            = (state != HALTED);
  assign link_addr         = pc + 32'd8;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, bus stalls, branches, jumps, halt and reset.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic [1:0]  pc_sel;
  logic        branch_cond;
  logic [31:0] rs_data;
  logic        exec_stall;
  logic [31:0] instr_readdata, pc, link_addr;
  logic        instr_valid, active;
  int          errors = 0;
  int          checks = 0;

  localparam logic [31:0] RV  = 32'hBFC00000;
  localparam logic [31:0] NOP = 32'h00000000;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_VECTOR(32'hBFC00000), .HALT_ADDR(32'h00000000)) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .bus            (bus),
    .instr_readdata (instr_readdata),
    .instr_valid    (instr_valid),
    .pc             (pc),
    .link_addr      (link_addr),
    .pc_sel         (pc_sel),
    .branch_cond    (branch_cond),
    .rs_data        (rs_data),
    .exec_stall     (exec_stall),
    .active         (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.instr_waitrequest = 1'b0;
    cyc();
    cyc();
    check("rst_read", 32'(bus.instr_read), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_active", 32'(active), 32'd1);
    check("rst_pc", pc, RV);
    check("rst_ir", instr_readdata, 32'd0);
  endtask

  // Check the outstanding read, complete it with 'word', then check the EXEC view.
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] word);
    check({tag, "_read"}, 32'(bus.instr_read), 32'd1);
    check({tag, "_addr"}, bus.instr_address, addr);
    check({tag, "_vld0"}, 32'(instr_valid), 32'd0);
    bus.instr_rdata = word;
    bus.instr_waitrequest = 1'b0;
    cyc();
    check({tag, "_vld1"}, 32'(instr_valid), 32'd1);
    check({tag, "_ir"}, instr_readdata, word);
    check({tag, "_pc"}, pc, addr);
    check({tag, "_link"}, link_addr, addr + 32'd8);
  endtask

  task automatic exec(input logic [1:0] sel, input logic cond, input logic [31:0] rs);
    pc_sel = sel;
    branch_cond = cond;
    rs_data = rs;
    cyc();
    pc_sel = 2'b00;
    branch_cond = 1'b0;
    rs_data = 32'd0;
  endtask

  initial begin
    reset = 1'b1;
    clk_enable = 1'b1;
    pc_sel = 2'b00;
    branch_cond = 1'b0;
    rs_data = 32'd0;
    exec_stall = 1'b0;
    bus.instr_waitrequest = 1'b0;
    bus.instr_rdata = NOP;

    // ADDIU at the reset vector, then sequential fetch.
    do_reset();
    check("seq_link0", link_addr, 32'hBFC00008);
    fetch("addiu", RV, 32'h24010005);
    check("addiu_read", 32'(bus.instr_read), 32'd0);
    exec(2'b00, 1'b0, 32'd0);
    check("seq_next", bus.instr_address, 32'hBFC00004);

    // Three waitrequest cycles: read held with a stable address.
    do_reset();
    bus.instr_waitrequest = 1'b1;
    bus.instr_rdata = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("wait_read", 32'(bus.instr_read), 32'd1);
      check("wait_addr", bus.instr_address, RV);
      check("wait_vld", 32'(instr_valid), 32'd0);
    end
    fetch("afterwait", RV, NOP);
    clk_enable = 1'b0;
    cyc();
    cyc();
    check("ce_exec_vld", 32'(instr_valid), 32'd1);
    check("ce_exec_pc", pc, RV);
    clk_enable = 1'b1;
    exec(2'b00, 1'b0, 32'd0);
    clk_enable = 1'b0;
    bus.instr_rdata = 32'h22222222;
    cyc();
    check("ce_fetch_vld", 32'(instr_valid), 32'd0);
    check("ce_fetch_addr", bus.instr_address, 32'hBFC00004);
    clk_enable = 1'b1;

    // BEQ taken, imm=4: delay slot BFC00004, target BFC00014.
    do_reset();
    fetch("beq_t", RV, 32'h10000004);
    exec(2'b01, 1'b1, 32'd0);
    fetch("beq_t_ds", 32'hBFC00004, NOP);
    exec(2'b00, 1'b0, 32'd0);
    check("beq_t_tgt", bus.instr_address, 32'hBFC00014);

    // BEQ not taken.
    do_reset();
    fetch("beq_n", RV, 32'h10000004);
    exec(2'b01, 1'b0, 32'd0);
    fetch("beq_n_ds", 32'hBFC00004, NOP);
    exec(2'b00, 1'b0, 32'd0);
    check("beq_n_tgt", bus.instr_address, 32'hBFC00008);

    // Negative offset: imm=FFFF -> BFC00004-4.
    do_reset();
    fetch("bneg", RV, 32'h1420FFFF);
    exec(2'b01, 1'b1, 32'd0);
    fetch("bneg_ds", 32'hBFC00004, NOP);
    exec(2'b00, 1'b0, 32'd0);
    check("bneg_tgt", bus.instr_address, RV);

    // JR to an unaligned FFFFFFFF masks to FFFFFFFC; pc+4 then wraps to 0 without halting.
    do_reset();
    fetch("jrw", RV, 32'h00200008);
    exec(2'b11, 1'b0, 32'hFFFFFFFF);
    fetch("jrw_ds", 32'hBFC00004, NOP);
    exec(2'b00, 1'b0, 32'd0);
    fetch("wrap", 32'hFFFFFFFC, NOP);
    exec(2'b00, 1'b0, 32'd0);
    check("wrap_addr", bus.instr_address, 32'h00000000);
    check("wrap_active", 32'(active), 32'd1);

    // JR $0 at BFC00010 halts after its delay slot.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      fetch("pre", RV + 32'(4 * i), NOP);
      exec(2'b00, 1'b0, 32'd0);
    end
    fetch("jr0", 32'hBFC00010, 32'h00000008);
    exec(2'b11, 1'b0, 32'd0);
    fetch("jr0_ds", 32'hBFC00014, NOP);
    exec(2'b00, 1'b0, 32'd0);
    check("halt_active", 32'(active), 32'd0);
    check("halt_pc", pc, 32'h00000000);
    check("halt_link", link_addr, 32'h00000008);
    bus.instr_waitrequest = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("halt_read", 32'(bus.instr_read), 32'd0);
      check("halt_vld", 32'(instr_valid), 32'd0);
      check("halt_hold", 32'(active), 32'd0);
    end

    // J with two exec_stall cycles; a J in the delay slot is discarded.
    do_reset();
    fetch("j", RV, 32'h08000040);
    exec_stall = 1'b1;
    pc_sel = 2'b10;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("stall_vld", 32'(instr_valid), 32'd1);
      check("stall_pc", pc, RV);
    end
    exec_stall = 1'b0;
    exec(2'b10, 1'b0, 32'd0);
    fetch("j_ds", 32'hBFC00004, 32'h08000080);
    exec(2'b10, 1'b0, 32'd0);
    fetch("j_tgt", 32'hB0000100, NOP);
    exec(2'b00, 1'b0, 32'd0);
    check("j_after", bus.instr_address, 32'hB0000104);

    // Reset during a stalled FETCH; the bus response during reset is ignored.
    bus.instr_waitrequest = 1'b1;
    cyc();
    check("mid_read", 32'(bus.instr_read), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_read", 32'(bus.instr_read), 32'd0);
    bus.instr_waitrequest = 1'b0;
    bus.instr_rdata = 32'hDEADBEEF;
    cyc();
    check("mid_rst_vld", 32'(instr_valid), 32'd0);
    check("mid_rst_ir", instr_readdata, 32'd0);
    reset = 1'b0;
    #1;
    check("mid_after_addr", bus.instr_address, RV);
    check("mid_after_read", 32'(bus.instr_read), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
